// File: rtl/uart_cmd_bus_master_pkg.sv
// uart_cmd_bus_master_pkg: shared FSM states, reply characters and ASCII-hex classification.
package uart_cmd_bus_master_pkg;

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_DATA, S_DISCARD, S_BUS, S_RDWAIT, S_TX
    } state_t;

    typedef enum logic [1:0] {RP_K, RP_E, RP_T, RP_RD} reply_t;

    localparam logic [7:0] CH_K     = 8'h4B;
    localparam logic [7:0] CH_E     = 8'h45;
    localparam logic [7:0] CH_T     = 8'h54;
    localparam logic [7:0] CH_NL    = 8'h0A;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_COMMA = 8'h2C;

    // Returns {digit_valid, nibble}; letters a-f/A-F share their low nibble, offset by 9.
    function automatic logic [4:0] hex_classify(input logic [7:0] c);
        if (c >= 8'h30 && c <= 8'h39) return {1'b1, c[3:0]};
        if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66)) return {1'b1, c[3:0] + 4'd9};
        return 5'd0;
    endfunction

endpackage

// File: rtl/uart_cmd_hex_codec.sv
// uart_cmd_hex_codec: combinational ASCII-to-nibble decoder and nibble-to-uppercase-ASCII encoder.
module uart_cmd_hex_codec
    import uart_cmd_bus_master_pkg::*;
(
    input  logic [7:0] i_ascii,
    output logic [3:0] o_nibble,
    output logic       o_digit_valid,
    input  logic [3:0] i_nibble,
    output logic [7:0] o_ascii
);

    logic [4:0] w_class;

    assign w_class       = hex_classify(i_ascii);
    assign o_digit_valid = w_class[4];
    assign o_nibble      = w_class[3:0];
    assign o_ascii       = (i_nibble < 4'd10) ? {4'h3, i_nibble} : {4'h4, i_nibble - 4'd9};

endmodule

// File: rtl/uart_cmd_bus_master.sv
// uart_cmd_bus_master: parses "W<addr>,<data>\n" / "R<addr>\n" from a UART byte stream, runs one
// bus transaction per command and streams an ASCII reply. Define UART_CMD_TIMEOUT_EN to abort a
// transaction stuck on busy_i after TimeoutCycles and reply "T\n".
module uart_cmd_bus_master
    import uart_cmd_bus_master_pkg::*;
#(
    parameter int AddrWidth     = 16,
    parameter int DataWidth     = 32,
    parameter int ReadLatency   = 1,
    parameter int TimeoutCycles = 1024
) (
    input  logic                 clk_i,
    input  logic                 reset_ni,
    input  logic [7:0]           rx_data_i,
    input  logic                 rx_valid_i,
    output logic                 rx_ready_o,
    output logic [7:0]           tx_data_o,
    output logic                 tx_valid_o,
    input  logic                 tx_ready_i,
    output logic [AddrWidth-1:0] address_o,
    output logic [DataWidth-1:0] data_o,
    output logic                 we_o,
    output logic                 bus_valid_o,
    input  logic                 busy_i,
    input  logic [DataWidth-1:0] data_i
);

    localparam int AN = AddrWidth / 4;
    localparam int DN = DataWidth / 4;
    localparam int CW = $clog2((AN > DN ? AN : DN) + 1);
    localparam int IW = $clog2(DN + 1);
    localparam logic [1:0] LAT = 2'(ReadLatency);

    state_t               r_state;
    reply_t               r_reply;
    logic                 r_is_write, r_rx_ready, r_bus_valid, r_tx_valid;
    logic [AddrWidth-1:0] r_addr;
    logic [DataWidth-1:0] r_data, r_rdata;
    logic [CW-1:0]        r_cnt;
    logic [IW-1:0]        r_idx;
    logic [1:0]           r_lat;
    logic                 w_acc, w_hex, w_nl, w_cr, w_comma, w_let_w, w_let_r, w_full, w_last;
    logic [3:0]           w_nib, w_tx_nib;
    logic [7:0]           w_hex_ascii, w_char;
    logic [DataWidth-1:0] w_shifted;
`ifdef UART_CMD_TIMEOUT_EN
    localparam int TW = $clog2(TimeoutCycles + 1);
    logic [TW-1:0]        r_tmo;
`endif

    uart_cmd_hex_codec u_codec (
        .i_ascii      (rx_data_i),
        .o_nibble     (w_nib),
        .o_digit_valid(w_hex),
        .i_nibble     (w_tx_nib),
        .o_ascii      (w_hex_ascii)
    );

    assign w_acc     = rx_valid_i && r_rx_ready;
    assign w_nl      = rx_data_i == CH_NL;
    assign w_cr      = rx_data_i == CH_CR;
    assign w_comma   = rx_data_i == CH_COMMA;
    assign w_let_w   = rx_data_i == 8'h57 || rx_data_i == 8'h77;
    assign w_let_r   = rx_data_i == 8'h52 || rx_data_i == 8'h72;
    assign w_full    = r_cnt == ((r_state == S_DATA) ? CW'(DN) : CW'(AN));
    assign w_shifted = r_rdata << {r_idx, 2'b00};
    assign w_tx_nib  = w_shifted[DataWidth-1 -: 4];
    assign w_last    = (r_reply == RP_RD) ? (r_idx == IW'(DN)) : (r_idx == IW'(1));
    assign w_char    = (r_reply == RP_RD) ? (w_last ? CH_NL : w_hex_ascii) :
                       (r_idx != '0) ? CH_NL :
                       (r_reply == RP_K) ? CH_K : (r_reply == RP_E) ? CH_E : CH_T;

    assign rx_ready_o  = r_rx_ready;
    assign tx_valid_o  = r_tx_valid;
    assign tx_data_o   = r_tx_valid ? w_char : 8'h00;
    assign bus_valid_o = r_bus_valid;
    assign we_o        = r_bus_valid && r_is_write;
    assign address_o   = r_addr;
    assign data_o      = r_data;

    // Command FSM: parse, run one bus transaction, then stream the reply.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state     <= S_IDLE;
            r_reply     <= RP_K;
            r_is_write  <= 1'b0;
            r_rx_ready  <= 1'b0;
            r_bus_valid <= 1'b0;
            r_tx_valid  <= 1'b0;
            r_addr      <= '0;
            r_data      <= '0;
            r_rdata     <= '0;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_lat       <= '0;
`ifdef UART_CMD_TIMEOUT_EN
            r_tmo       <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_rx_ready <= 1'b1;
                    if (w_acc && !w_nl && !w_cr) begin
                        r_is_write <= w_let_w;
                        r_addr     <= '0;
                        r_data     <= '0;
                        r_cnt      <= '0;
                        r_state    <= (w_let_w || w_let_r) ? S_ADDR : S_DISCARD;
                    end
                end
                S_ADDR, S_DATA: begin
                    if (w_acc && !w_cr) begin
                        if (w_hex && !w_full) begin
                            r_cnt <= r_cnt + 1'b1;
                            if (r_state == S_ADDR) r_addr <= AddrWidth'({r_addr, w_nib});
                            else r_data <= DataWidth'({r_data, w_nib});
                        end else if (w_comma && r_state == S_ADDR && r_is_write && r_cnt != '0) begin
                            r_cnt   <= '0;
                            r_state <= S_DATA;
                        end else if (w_nl && r_cnt != '0 && (r_state == S_DATA || !r_is_write)) begin
                            r_state     <= S_BUS;
                            r_bus_valid <= 1'b1;
                            r_rx_ready  <= 1'b0;
`ifdef UART_CMD_TIMEOUT_EN
                            r_tmo       <= '0;
`endif
                        end else if (w_nl) begin
                            r_state    <= S_TX;
                            r_reply    <= RP_E;
                            r_tx_valid <= 1'b1;
                            r_rx_ready <= 1'b0;
                        end else begin
                            r_state <= S_DISCARD;
                        end
                    end
                end
                S_DISCARD: begin
                    if (w_acc && w_nl) begin
                        r_state    <= S_TX;
                        r_reply    <= RP_E;
                        r_tx_valid <= 1'b1;
                        r_rx_ready <= 1'b0;
                    end
                end
                S_BUS: begin
                    if (!busy_i) begin
                        r_bus_valid <= 1'b0;
                        if (r_is_write) begin
                            r_state    <= S_TX;
                            r_reply    <= RP_K;
                            r_tx_valid <= 1'b1;
                        end else if (ReadLatency == 0) begin
                            r_rdata    <= data_i;
                            r_state    <= S_TX;
                            r_reply    <= RP_RD;
                            r_tx_valid <= 1'b1;
                        end else begin
                            r_lat   <= 2'd1;
                            r_state <= S_RDWAIT;
                        end
                    end
`ifdef UART_CMD_TIMEOUT_EN
                    else if (r_tmo == TW'(TimeoutCycles - 1)) begin
                        r_bus_valid <= 1'b0;
                        r_state     <= S_TX;
                        r_reply     <= RP_T;
                        r_tx_valid  <= 1'b1;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
`endif
                end
                S_RDWAIT: begin
                    if (r_lat == LAT) begin
                        r_rdata    <= data_i;
                        r_state    <= S_TX;
                        r_reply    <= RP_RD;
                        r_tx_valid <= 1'b1;
                    end else begin
                        r_lat <= r_lat + 1'b1;
                    end
                end
                S_TX: begin
                    if (r_tx_valid && tx_ready_i) begin
                        if (w_last) begin
                            r_tx_valid <= 1'b0;
                            r_idx      <= '0;
                            r_state    <= S_IDLE;
                            r_rx_ready <= 1'b1;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_bus_master.sv
// tb_uart_cmd_bus_master: directed checks of parsing, bus handshake, replies, errors, timeout and reset.
module tb_uart_cmd_bus_master;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready_o;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready = 1'b1;
    logic [15:0] address_o;
    logic [31:0] data_o;
    logic        we_o;
    logic        bus_valid_o;
    logic        busy = 1'b0;
    logic [31:0] data_in = 32'hFFFF_FFFF;
    logic [31:0] rd_word = 32'h0;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int nl_cyc = 0;
    int bus_cycles, bursts, first_bus_cyc, first_tx_cyc;
    logic prev_bv = 1'b0;
    logic unstable, rep_done;
    logic [15:0] b_addr;
    logic [31:0] b_data;
    logic b_we;
    string rep;
    string errs[4] = '{"W12,\n", "X1\n", "R12345\n", "R1,2\n"};

    always #5 clk = ~clk;

    uart_cmd_bus_master dut (
        .clk_i      (clk),
        .reset_ni   (reset_n),
        .rx_data_i  (rx_data),
        .rx_valid_i (rx_valid),
        .rx_ready_o (rx_ready_o),
        .tx_data_o  (tx_data_o),
        .tx_valid_o (tx_valid_o),
        .tx_ready_i (tx_ready),
        .address_o  (address_o),
        .data_o     (data_o),
        .we_o       (we_o),
        .bus_valid_o(bus_valid_o),
        .busy_i     (busy),
        .data_i     (data_in)
    );

    // Slave model: read data is valid only in the single cycle after read completion (ReadLatency 1).
    always @(posedge clk) begin
        cyc <= cyc + 1;
        data_in <= (bus_valid_o && !busy && !we_o) ? rd_word : 32'hFFFF_FFFF;
    end

    // Bus and reply monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus_valid_o) begin
            if (bus_cycles == 0) begin
                b_addr = address_o;
                b_data = data_o;
                b_we = we_o;
                first_bus_cyc = cyc;
            end else if (address_o !== b_addr || data_o !== b_data || we_o !== b_we) begin
                unstable = 1'b1;
            end
            bus_cycles++;
            if (!prev_bv) bursts++;
        end
        prev_bv = bus_valid_o;
        if (tx_valid_o && first_tx_cyc < 0) first_tx_cyc = cyc;
        if (tx_valid_o && tx_ready) begin
            rep = $sformatf("%s%c", rep, tx_data_o);
            if (tx_data_o == 8'h0A) rep_done = 1'b1;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_s(input string tag, input string got, input string exp);
        n_checks++;
        assert (got == exp) else begin
            n_fail++;
            $error("FAIL %s: got '%s', expected '%s'", tag, got, exp);
        end
    endtask

    task automatic clr();
        @(posedge clk);
        #1;
        bus_cycles = 0;
        bursts = 0;
        first_bus_cyc = -1;
        first_tx_cyc = -1;
        unstable = 1'b0;
        rep_done = 1'b0;
        rep = "";
        @(negedge clk);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            int n = 0;
            rx_data = s[i];
            rx_valid = 1'b1;
            while (!rx_ready_o && n < 100) begin
                @(negedge clk);
                n++;
            end
            if (n == 100) chk("rx_ready_wait", 0, 1);
            @(negedge clk);
            rx_valid = 1'b0;
        end
        nl_cyc = cyc;
    endtask

    task automatic wait_reply(input int budget);
        int n = 0;
        while (!rep_done && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("reply_done", rep_done, 1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_bus_valid", bus_valid_o, 0);
        chk("rst_tx_valid", tx_valid_o, 0);
        chk("rst_rx_ready", rx_ready_o, 0);
        chk("rst_tx_data", tx_data_o, 0);
        chk("rst_address", address_o, 0);
        chk("rst_data", data_o, 0);
        chk("rst_we", we_o, 0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rx_ready_after_release", rx_ready_o, 1);

        clr();
        send_str("\n");
        repeat (5) @(negedge clk);
        chk_s("bare_nl_reply", rep, "");
        chk("bare_nl_bus", bursts, 0);
        chk("bare_nl_rx_ready", rx_ready_o, 1);

        clr();
        send_str("W9004,DEADBEEF\n");
        wait_reply(20);
        chk_s("wr_reply", rep, "K\n");
        chk("wr_bursts", bursts, 1);
        chk("wr_bus_cycles", bus_cycles, 1);
        chk("wr_addr", b_addr, 16'h9004);
        chk("wr_data", b_data, 32'hDEADBEEF);
        chk("wr_we", b_we, 1);
        chk("wr_bus_latency", first_bus_cyc, nl_cyc);
        chk("wr_tx_latency", first_tx_cyc, nl_cyc + 1);

        clr();
        rd_word = 32'h0000ABCD;
        tx_ready = 1'b0;
        send_str("r9000\n");
        repeat (6) @(negedge clk);
        chk("rd_stall_valid", tx_valid_o, 1);
        chk("rd_stall_data", tx_data_o, 8'h30);
        chk("rd_stall_rx_ready", rx_ready_o, 0);
        tx_ready = 1'b1;
        wait_reply(30);
        chk_s("rd_reply", rep, "0000ABCD\n");
        chk("rd_bus_cycles", bus_cycles, 1);
        chk("rd_addr", b_addr, 16'h9000);
        chk("rd_we", b_we, 0);
        chk("rd_tx_latency", first_tx_cyc, nl_cyc + 2);

        clr();
        busy = 1'b1;
        send_str("W8000,5\n");
        repeat (20) @(negedge clk);
        busy = 1'b0;
        wait_reply(20);
        chk_s("busy_reply", rep, "K\n");
        chk("busy_bus_cycles", bus_cycles, 21);
        chk("busy_bursts", bursts, 1);
        chk("busy_stable", unstable, 0);
        chk("busy_addr", b_addr, 16'h8000);
        chk("busy_data", b_data, 32'h00000005);

        for (int i = 0; i < 4; i++) begin
            clr();
            send_str(errs[i]);
            wait_reply(30);
            chk_s($sformatf("err%0d_reply", i), rep, "E\n");
            chk($sformatf("err%0d_bus", i), bursts, 0);
        end

        clr();
        rd_word = 32'hC0FFEE01;
        send_str("R0\r\n");
        wait_reply(30);
        chk_s("r0_reply", rep, "C0FFEE01\n");
        chk("r0_bursts", bursts, 1);
        chk("r0_addr", b_addr, 16'h0000);

        clr();
        busy = 1'b1;
        send_str("W1234,1\n");
        repeat (2000) @(negedge clk);
`ifdef UART_CMD_TIMEOUT_EN
        chk_s("tmo_reply", rep, "T\n");
        chk("tmo_bus_cycles", bus_cycles, 1024);
        chk("tmo_bursts", bursts, 1);
        busy = 1'b0;
`else
        chk("pending_bus_valid", bus_valid_o, 1);
        chk_s("pending_reply", rep, "");
        busy = 1'b0;
        wait_reply(20);
        chk_s("late_reply", rep, "K\n");
        chk("late_bus_cycles", bus_cycles, 2001);
        chk("late_bursts", bursts, 1);
`endif

        clr();
        rd_word = 32'h12345678;
        send_str("R9000\n");
        repeat (4) @(negedge clk);
        chk("third_byte", tx_data_o, 8'h33);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_tx_valid", tx_valid_o, 0);
        chk("mid_rst_tx_data", tx_data_o, 0);
        chk("mid_rst_bus_valid", bus_valid_o, 0);
        chk("mid_rst_rx_ready", rx_ready_o, 0);
        chk("mid_rst_address", address_o, 0);
        chk("mid_rst_data", data_o, 0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("release_rx_ready_low", rx_ready_o, 0);
        @(negedge clk);
        chk("release_rx_ready_high", rx_ready_o, 1);

        clr();
        send_str("W1,1\n");
        wait_reply(20);
        chk_s("post_rst_reply", rep, "K\n");
        chk("post_rst_addr", b_addr, 16'h0001);
        chk("post_rst_data", b_data, 32'h00000001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
